dual_writeback_regfile: RTL and testbench

Dual-lane writeback stage and architectural register file for the dual-issue core. Consumes the registered lane-1/lane-2 writeback bundle (RegWrite, ResultSrc, ALUResult, ReadData, Rd, PCPlus8), selects each lane's result, and commits up to two register writes per cycle. Serves four combinational read ports to the decode stage, two per lane, and exports a0 for test observation.

---
 rtl/writeback_pkg.sv | 11 +
 rtl/writeback_result_mux.sv | 24 ++
 rtl/dual_writeback_regfile.sv | 112 +++++++++++
 tb/tb_dual_writeback_regfile.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// Shared writeback encodings and register index constants for the dual-issue core.
package writeback_pkg;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC8 = 2'b10;

    localparam int X0_INDEX = 0;
    localparam int A0_INDEX = 10;

endpackage

// File: rtl/writeback_result_mux.sv
// Per-lane writeback result select: ALU result, load data or link value; code 11 yields zero.
module writeback_result_mux
    import writeback_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            src,
    input  logic [DATA_WIDTH-1:0] alu,
    input  logic [DATA_WIDTH-1:0] mem,
    input  logic [DATA_WIDTH-1:0] pc8,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        unique case (src)
            RESULT_ALU: result = alu;
            RESULT_MEM: result = mem;
            RESULT_PC8: result = pc8;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/dual_writeback_regfile.sv
// Dual-lane writeback stage and register file with four combinational read ports and a0 tap.
// Define WRITEBACK_BYPASS_EN to forward same-cycle writeback values onto the read ports and a0.
module dual_writeback_regfile
    import writeback_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    localparam int IDX_W     = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteW1,
    input  logic                  RegWriteW2,
    input  logic [1:0]            ResultSrcW1,
    input  logic [1:0]            ResultSrcW2,
    input  logic [DATA_WIDTH-1:0] ALUResultW1,
    input  logic [DATA_WIDTH-1:0] ALUResultW2,
    input  logic [DATA_WIDTH-1:0] ReadDataW1,
    input  logic [DATA_WIDTH-1:0] ReadDataW2,
    input  logic [DATA_WIDTH-1:0] PCPlus8W1,
    input  logic [DATA_WIDTH-1:0] PCPlus8W2,
    input  logic [IDX_W-1:0]      RdW1,
    input  logic [IDX_W-1:0]      RdW2,
    input  logic [IDX_W-1:0]      A1_1,
    input  logic [IDX_W-1:0]      A2_1,
    input  logic [IDX_W-1:0]      A1_2,
    input  logic [IDX_W-1:0]      A2_2,
    output logic [DATA_WIDTH-1:0] RD1_1,
    output logic [DATA_WIDTH-1:0] RD2_1,
    output logic [DATA_WIDTH-1:0] RD1_2,
    output logic [DATA_WIDTH-1:0] RD2_2,
    output logic [DATA_WIDTH-1:0] ResultW1,
    output logic [DATA_WIDTH-1:0] ResultW2,
    output logic [DATA_WIDTH-1:0] a0
);

    localparam logic [IDX_W-1:0] X0 = IDX_W'(X0_INDEX);
    localparam logic [IDX_W-1:0] A0 = IDX_W'(A0_INDEX);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic                  commit1;
    logic                  commit2;

    writeback_result_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux_lane1 (
        .src    (ResultSrcW1),
        .alu    (ALUResultW1),
        .mem    (ReadDataW1),
        .pc8    (PCPlus8W1),
        .result (ResultW1)
    );

    writeback_result_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux_lane2 (
        .src    (ResultSrcW2),
        .alu    (ALUResultW2),
        .mem    (ReadDataW2),
        .pc8    (PCPlus8W2),
        .result (ResultW2)
    );

    assign commit1 = RegWriteW1 && (RdW1 != X0);
    assign commit2 = RegWriteW2 && (RdW2 != X0);

    // Lane 2 is the younger instruction, so its write is issued last and wins a shared Rd.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (commit1) regs[RdW1] <= ResultW1;
            if (commit2) regs[RdW2] <= ResultW2;
        end
    end

`ifdef WRITEBACK_BYPASS_EN
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [IDX_W-1:0]      addr,
        input logic [DATA_WIDTH-1:0] arr,
        input logic                  c1,
        input logic [IDX_W-1:0]      rd1,
        input logic [DATA_WIDTH-1:0] r1,
        input logic                  c2,
        input logic [IDX_W-1:0]      rd2,
        input logic [DATA_WIDTH-1:0] r2
    );
        if (addr == X0)               return '0;
        if (c2 && (addr == rd2))      return r2;
        if (c1 && (addr == rd1))      return r1;
        return arr;
    endfunction

    assign RD1_1 = read_port(A1_1, regs[A1_1], commit1, RdW1, ResultW1, commit2, RdW2, ResultW2);
    assign RD2_1 = read_port(A2_1, regs[A2_1], commit1, RdW1, ResultW1, commit2, RdW2, ResultW2);
    assign RD1_2 = read_port(A1_2, regs[A1_2], commit1, RdW1, ResultW1, commit2, RdW2, ResultW2);
    assign RD2_2 = read_port(A2_2, regs[A2_2], commit1, RdW1, ResultW1, commit2, RdW2, ResultW2);
    assign a0    = read_port(A0,   regs[A0],   commit1, RdW1, ResultW1, commit2, RdW2, ResultW2);
`else
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [IDX_W-1:0]      addr,
        input logic [DATA_WIDTH-1:0] arr
    );
        return (addr == X0) ? '0 : arr;
    endfunction

    assign RD1_1 = read_port(A1_1, regs[A1_1]);
    assign RD2_1 = read_port(A2_1, regs[A2_1]);
    assign RD1_2 = read_port(A1_2, regs[A1_2]);
    assign RD2_2 = read_port(A2_2, regs[A2_2]);
    assign a0    = regs[A0];
`endif

endmodule

// File: tb/tb_dual_writeback_regfile.sv
// Self-checking bench for dual_writeback_regfile: directed vector table, corner sequences, random vs. model.
module tb_dual_writeback_regfile;

`ifdef WRITEBACK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteW1, RegWriteW2;
    logic [1:0]  ResultSrcW1, ResultSrcW2;
    logic [31:0] ALUResultW1, ALUResultW2, ReadDataW1, ReadDataW2, PCPlus8W1, PCPlus8W2;
    logic [4:0]  RdW1, RdW2, A1_1, A2_1, A1_2, A2_2;
    logic [31:0] RD1_1, RD2_1, RD1_2, RD2_2, ResultW1, ResultW2, a0;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];

    always #5 clk = ~clk;

    dual_writeback_regfile #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteW1(RegWriteW1), .RegWriteW2(RegWriteW2),
        .ResultSrcW1(ResultSrcW1), .ResultSrcW2(ResultSrcW2),
        .ALUResultW1(ALUResultW1), .ALUResultW2(ALUResultW2),
        .ReadDataW1(ReadDataW1), .ReadDataW2(ReadDataW2),
        .PCPlus8W1(PCPlus8W1), .PCPlus8W2(PCPlus8W2),
        .RdW1(RdW1), .RdW2(RdW2),
        .A1_1(A1_1), .A2_1(A2_1), .A1_2(A1_2), .A2_2(A2_2),
        .RD1_1(RD1_1), .RD2_1(RD2_1), .RD1_2(RD1_2), .RD2_2(RD2_2),
        .ResultW1(ResultW1), .ResultW2(ResultW2), .a0(a0)
    );

    typedef struct {
        logic        rw1; logic [1:0] s1; logic [31:0] v1; logic [4:0] rd1;
        logic        rw2; logic [1:0] s2; logic [31:0] v2; logic [4:0] rd2;
        logic [4:0]  ra;  logic [4:0] rb;
        logic [31:0] eres1, eres2, ea, eb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Place v on the selected source only; the other sources carry distinct junk.
    task automatic drive_lane1(input logic rw, input logic [1:0] s, input logic [31:0] v, input logic [4:0] rd);
        RegWriteW1  = rw; ResultSrcW1 = s; RdW1 = rd;
        ALUResultW1 = (s == 2'b00) ? v : 32'hA1A1A1A1;
        ReadDataW1  = (s == 2'b01) ? v : 32'hB2B2B2B2;
        PCPlus8W1   = (s == 2'b10) ? v : 32'hC3C3C3C3;
    endtask

    task automatic drive_lane2(input logic rw, input logic [1:0] s, input logic [31:0] v, input logic [4:0] rd);
        RegWriteW2  = rw; ResultSrcW2 = s; RdW2 = rd;
        ALUResultW2 = (s == 2'b00) ? v : 32'hD4D4D4D4;
        ReadDataW2  = (s == 2'b01) ? v : 32'hE5E5E5E5;
        PCPlus8W2   = (s == 2'b10) ? v : 32'hF6F6F6F6;
    endtask

    task automatic idle();
        drive_lane1(1'b0, 2'b00, 32'h0, 5'd0);
        drive_lane2(1'b0, 2'b00, 32'h0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sel(input logic [1:0] s, input logic [31:0] alu, mem, pc);
        case (s)
            2'b00:   return alu;
            2'b01:   return mem;
            2'b10:   return pc;
            default: return 32'h0;
        endcase
    endfunction

    // Expected read value: x0 is zero, the younger lane forwards first when bypass exists.
    function automatic logic [31:0] exp_read(input logic [4:0] a, input logic [31:0] r1, r2);
        if (a == 5'd0) return 32'h0;
        if (BYP && RegWriteW2 && RdW2 != 5'd0 && a == RdW2) return r2;
        if (BYP && RegWriteW1 && RdW1 != 5'd0 && a == RdW1) return r1;
        return model[a];
    endfunction

    vec_t vecs [6];

    initial begin
        rst = 1'b1;
        idle();
        A1_1 = 5'd0; A2_1 = 5'd0; A1_2 = 5'd0; A2_2 = 5'd0;
        step();
        A1_1 = 5'd5; A2_1 = 5'd31;
        chk("reset_rd_x5", RD1_1, 32'h0);
        chk("reset_rd_x31", RD2_1, 32'h0);
        chk("reset_a0", a0, 32'h0);

        // Write x5 and x10, then reset with a write still pending on that edge.
        rst = 1'b0;
        drive_lane1(1'b1, 2'b00, 32'hDEADBEEF, 5'd5);
        drive_lane2(1'b1, 2'b01, 32'h00000042, 5'd10);
        step();
        idle();
        chk("pre_reset_x5", RD1_1, 32'hDEADBEEF);
        chk("pre_reset_a0", a0, 32'h00000042);
        rst = 1'b1;
        drive_lane1(1'b1, 2'b00, 32'h12345678, 5'd6);
        A2_1 = 5'd6;
        step();
        rst = 1'b0;
        idle();
        chk("midreset_x5", RD1_1, 32'h0);
        chk("midreset_pending_x6", RD2_1, 32'h0);
        chk("midreset_a0", a0, 32'h0);

        vecs[0] = '{1'b1, 2'b00, 32'h11,   5'd3, 1'b1, 2'b01, 32'h22,   5'd4,  5'd3, 5'd4,  32'h11,   32'h22,   32'h11,   32'h22};
        vecs[1] = '{1'b1, 2'b00, 32'hAAAA, 5'd7, 1'b1, 2'b00, 32'hBBBB, 5'd7,  5'd7, 5'd3,  32'hAAAA, 32'hBBBB, 32'hBBBB, 32'h11};
        vecs[2] = '{1'b1, 2'b00, 32'h55,   5'd0, 1'b0, 2'b00, 32'h66,   5'd4,  5'd0, 5'd4,  32'h55,   32'h66,   32'h0,    32'h22};
        vecs[3] = '{1'b1, 2'b10, 32'h108,  5'd1, 1'b1, 2'b11, 32'h77,   5'd2,  5'd1, 5'd2,  32'h108,  32'h0,    32'h108,  32'h0};
        vecs[4] = '{1'b0, 2'b00, 32'h1234, 5'd3, 1'b1, 2'b01, 32'h5,    5'd31, 5'd3, 5'd31, 32'h1234, 32'h5,    32'h11,   32'h5};
        vecs[5] = '{1'b1, 2'b01, 32'h9,    5'd8, 1'b0, 2'b10, 32'h3,    5'd8,  5'd8, 5'd7,  32'h9,    32'h3,    32'h9,    32'hBBBB};

        for (int i = 0; i < 6; i++) begin
            drive_lane1(vecs[i].rw1, vecs[i].s1, vecs[i].v1, vecs[i].rd1);
            drive_lane2(vecs[i].rw2, vecs[i].s2, vecs[i].v2, vecs[i].rd2);
            #1;
            chk($sformatf("vec%0d_res1", i), ResultW1, vecs[i].eres1);
            chk($sformatf("vec%0d_res2", i), ResultW2, vecs[i].eres2);
            step();
            idle();
            A1_1 = vecs[i].ra; A2_1 = vecs[i].rb;
            #1;
            chk($sformatf("vec%0d_rd_a", i), RD1_1, vecs[i].ea);
            chk($sformatf("vec%0d_rd_b", i), RD2_1, vecs[i].eb);
        end

        // Same-cycle read of x10 while lane 1 writes it; x10 was last written 0x42 before reset, so now 0.
        drive_lane1(1'b1, 2'b00, 32'h42, 5'd10);
        step();
        drive_lane1(1'b1, 2'b00, 32'h99, 5'd10);
        A1_2 = 5'd10;
        #1;
        chk("hazard_rd1_2", RD1_2, BYP ? 32'h99 : 32'h42);
        chk("hazard_a0", a0, BYP ? 32'h99 : 32'h42);
        step();
        idle();
        chk("hazard_after_rd1_2", RD1_2, 32'h99);
        chk("hazard_after_a0", a0, 32'h99);

        // x0 write must never be forwarded.
        drive_lane1(1'b1, 2'b00, 32'h55, 5'd0);
        drive_lane2(1'b1, 2'b00, 32'h56, 5'd0);
        A2_2 = 5'd0;
        #1;
        chk("x0_bypass", RD2_2, 32'h0);
        step();
        idle();
        chk("x0_after", RD2_2, 32'h0);

        // Randomized phase against a register-array model, starting from a clean reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r1, r2;
            logic [4:0]  pick [4];
            logic        do_rst;
            RegWriteW1  = 1'($urandom_range(0, 3) != 0);
            RegWriteW2  = 1'($urandom_range(0, 3) != 0);
            ResultSrcW1 = 2'($urandom_range(0, 3));
            ResultSrcW2 = 2'($urandom_range(0, 3));
            ALUResultW1 = $urandom; ALUResultW2 = $urandom;
            ReadDataW1  = $urandom; ReadDataW2  = $urandom;
            PCPlus8W1   = $urandom; PCPlus8W2   = $urandom;
            RdW1 = 5'($urandom_range(0, 31));
            RdW2 = ($urandom_range(0, 3) == 0) ? RdW1 : 5'($urandom_range(0, 31));
            for (int p = 0; p < 4; p++) begin
                case ($urandom_range(0, 3))
                    0:       pick[p] = RdW1;
                    1:       pick[p] = RdW2;
                    2:       pick[p] = 5'd10;
                    default: pick[p] = 5'($urandom_range(0, 31));
                endcase
            end
            A1_1 = pick[0]; A2_1 = pick[1]; A1_2 = pick[2]; A2_2 = pick[3];
            do_rst = ($urandom_range(0, 49) == 0);
            rst = do_rst;
            r1 = sel(ResultSrcW1, ALUResultW1, ReadDataW1, PCPlus8W1);
            r2 = sel(ResultSrcW2, ALUResultW2, ReadDataW2, PCPlus8W2);
            #1;
            chk("rand_res1", ResultW1, r1);
            chk("rand_res2", ResultW2, r2);
            chk("rand_rd1_1", RD1_1, exp_read(A1_1, r1, r2));
            chk("rand_rd2_1", RD2_1, exp_read(A2_1, r1, r2));
            chk("rand_rd1_2", RD1_2, exp_read(A1_2, r1, r2));
            chk("rand_rd2_2", RD2_2, exp_read(A2_2, r1, r2));
            chk("rand_a0", a0, exp_read(5'd10, r1, r2));
            step();
            if (do_rst) begin
                for (int i = 0; i < 32; i++) model[i] = 32'h0;
            end else begin
                if (RegWriteW1 && RdW1 != 5'd0) model[RdW1] = r1;
                if (RegWriteW2 && RdW2 != 5'd0) model[RdW2] = r2;
            end
        end
        rst = 1'b0;
        idle();
        A1_1 = 5'd10;
        #1;
        chk("final_x10", RD1_1, model[10]);
        chk("final_a0", a0, model[10]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
